axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
// - Shares the single AXI-bridge read port between icache (port 0) and dcache (port 1).
// - Grants one requester at a time and holds the grant for the whole burst.
// - Routes return beats only to the granted requester.
// - Checks beat count against rd_type; flags protocol errors.
// - Sits between both caches' rd_*/ret_* interfaces and the axi bridge read side.
// PARAMETERS
// - RR_EN       1  1: round-robin between ports; 0: fixed priority, port 1 (dcache) wins
// - LINE_BEATS  4  beats expected for rd_type 3'b100 (cache line); any other type expects 1
// PORTS
// - clock         in   1    clock
// - reset         in   1    synchronous, active-high reset
// - m0_rd_req     in   1    icache read request; held until m0_rd_rdy
// - m0_rd_type    in   3    icache read type
// - m0_rd_addr    in   32   icache read address
// - m0_rd_rdy     out  1    request accepted by bridge (granted port only)
// - m0_ret_valid  out  1    return beat valid for icache
// - m0_ret_last   out  1    last return beat for icache
// - m1_rd_req, m1_rd_type, m1_rd_addr, m1_rd_rdy, m1_ret_valid, m1_ret_last
//                       same as m0_*, dcache
// - ret_data_o    out  32   bridge ret_data broadcast to both ports (qualify with mX_ret_valid)
// - rd_req        out  1    to bridge
// - rd_type       out  3    to bridge
// - rd_addr       out  32   to bridge
// - rd_rdy        in   1    bridge accepted request
// - ret_valid     in   1    bridge return beat valid
// - ret_last      in   1    bridge last beat
// - ret_data      in   32   bridge return data
// - busy          out  1    state != IDLE
// - proto_err     out  1    one-cycle pulse on protocol violation
// BEHAVIOUR
// - Reset values: state=IDLE, grant=0, last_grant=1, beat_cnt=0.
// - Outputs after reset: rd_req=0; rd_type=0; rd_addr=0; all mX_rd_rdy/ret_valid/ret_last=0; busy=0; proto_err=0.
// - States: IDLE, REQ, RECV.
// - IDLE
//   - Bridge outputs are 0.
//   - If any mX_rd_req is high, choose a winner, register grant and the winner's type/addr, go to REQ.
//   - If only one port requests, that port wins.
//   - On a tie with RR_EN=1, the port != last_grant wins. After reset, port 0 wins the first tie.
//   - On a tie with RR_EN=0, port 1 wins.
// - REQ
//   - rd_req=1; rd_type/rd_addr come from the registered copy.
//   - m[grant]_rd_rdy = rd_rdy; the other port's rd_rdy = 0.
//   - On rd_rdy: last_grant<=grant, beat_cnt<=0, exp<=(type==3'b100)?LINE_BEATS:1, go to RECV.
// - RECV
//   - m[grant]_ret_valid = ret_valid; the other port's ret_valid = 0.
//   - m[grant]_ret_last = ret_valid & (ret_last | beat_cnt==exp-1).
//   - On ret_valid: beat_cnt++.
//   - The transaction ends (go to IDLE) on a beat with ret_last or with beat_cnt==exp-1, whichever comes first.
//   - If ret_last and beat_cnt==exp-1 disagree on the ending beat, proto_err pulses that cycle.
// - Latency
//   - Requester rd_req -> bridge rd_req: 1 cycle (registered arbitration).
//   - Last beat -> next grant: one IDLE bubble cycle.
// - Losing requester: keeps rd_req high; it is served after the current burst.
//   - Under RR it wins the next arbitration even if the other port re-requests.
// - Requester drops rd_req while in REQ: the registered request is still issued (no cancel).
// - ret_valid in IDLE or REQ: beat dropped, no routing; proto_err pulses.
// - rd_rdy in IDLE or RECV: ignored.
// - Beat counter width: clog2(LINE_BEATS)+1 bits; never wraps (transaction ends at exp-1).
// - Reset mid-burst: state returns to IDLE next edge. Remaining bridge beats are treated as ret_valid in IDLE (dropped, proto_err).
// TESTING
// - m0 req addr 0x1c000000 type 4; rd_rdy after 2 cycles; 4 beats D0..D3 with ret_last on D3
//   -> m0 gets 4 ret_valid, m0_ret_last on D3 only, m1 sees none, proto_err=0.
// - m0 and m1 request same cycle, RR_EN=1, after reset -> port 0 first, then port 1 after one bubble cycle.
//   - Repeat with RR_EN=0 -> port 1 first.
// - m1 type 3'b010 (word) -> exp=1; single beat with ret_last -> done. Same beat without ret_last -> done, proto_err=1.
// - Line read: ret_last on beat 2 of 4 -> transaction ends at beat 2, proto_err pulses, m0_ret_last on beat 2.
// - ret_valid while IDLE -> no mX_ret_valid, proto_err=1 for one cycle.
// - Reset asserted after beat 1 of 4 -> next cycle busy=0, rd_req=0; trailing beats dropped with proto_err.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Read-port arbiter sharing one AXI-bridge read channel between icache (port 0)
// and dcache (port 1); holds the grant for a whole burst and polices beat counts.
module axi_rd_arbiter #(
    parameter int unsigned RR_EN      = 1,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_rd_req,
    input  logic [2:0]  m0_rd_type,
    input  logic [31:0] m0_rd_addr,
    output logic        m0_rd_rdy,
    output logic        m0_ret_valid,
    output logic        m0_ret_last,

    input  logic        m1_rd_req,
    input  logic [2:0]  m1_rd_type,
    input  logic [31:0] m1_rd_addr,
    output logic        m1_rd_rdy,
    output logic        m1_ret_valid,
    output logic        m1_ret_last,

    output logic [31:0] ret_data_o,

    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,

    output logic        busy,
    output logic        proto_err
);

    localparam int unsigned CW        = $clog2(LINE_BEATS) + 1;
    localparam logic [2:0]  TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV
    } state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] beat_cnt;
    // Index of the final expected beat (expected count minus one), kept
    // pre-decremented so the end-of-burst compare needs no subtractor.
    logic [CW-1:0] last_idx;

    logic any_req;
    logic winner;
    logic in_req;
    logic in_recv;
    logic cnt_end;
    logic beat_end;

    always_comb begin
        any_req = m0_rd_req | m1_rd_req;
        winner  = m1_rd_req;
        if (m0_rd_req && m1_rd_req) begin
            winner = (RR_EN != 0) ? ~last_grant : 1'b1;
        end
    end

    always_comb begin
        in_req   = (state == REQ);
        in_recv  = (state == RECV);
        cnt_end  = (beat_cnt == last_idx);
        beat_end = ret_last | cnt_end;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            last_idx   <= '0;
            rd_req     <= 1'b0;
            rd_type    <= '0;
            rd_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= winner;
                        rd_req  <= 1'b1;
                        rd_type <= winner ? m1_rd_type : m0_rd_type;
                        rd_addr <= winner ? m1_rd_addr : m0_rd_addr;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (rd_rdy) begin
                        last_grant <= grant;
                        beat_cnt   <= '0;
                        last_idx   <= (rd_type == TYPE_LINE) ? CW'(LINE_BEATS - 1) : '0;
                        rd_req     <= 1'b0;
                        rd_type    <= '0;
                        rd_addr    <= '0;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (ret_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_end) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and return routing follow the bridge combinationally, gated by grant.
    always_comb begin
        m0_rd_rdy    = in_req & ~grant & rd_rdy;
        m1_rd_rdy    = in_req &  grant & rd_rdy;
        m0_ret_valid = in_recv & ~grant & ret_valid;
        m1_ret_valid = in_recv &  grant & ret_valid;
        m0_ret_last  = m0_ret_valid & beat_end;
        m1_ret_last  = m1_ret_valid & beat_end;
        ret_data_o   = ret_data;
        busy         = (state != IDLE);
        proto_err    = ret_valid & (~in_recv | (ret_last ^ cnt_end));
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: round-robin instance is fully checked,
// a fixed-priority instance shares the inputs for the tie-break check.
module tb_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_rd_req, m1_rd_req;
    logic [2:0]  m0_rd_type, m1_rd_type;
    logic [31:0] m0_rd_addr, m1_rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;

    logic        m0_rd_rdy, m0_ret_valid, m0_ret_last;
    logic        m1_rd_rdy, m1_ret_valid, m1_ret_last;
    logic [31:0] ret_data_o, rd_addr;
    logic [2:0]  rd_type;
    logic        rd_req, busy, proto_err;

    logic        fp_m0_rd_rdy, fp_m0_ret_valid, fp_m0_ret_last;
    logic        fp_m1_rd_rdy, fp_m1_ret_valid, fp_m1_ret_last;
    logic [31:0] fp_ret_data_o, fp_rd_addr;
    logic [2:0]  fp_rd_type;
    logic        fp_rd_req, fp_busy, fp_proto_err;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    tests_run = 0;
    int    failures  = 0;

    axi_rd_arbiter #(.RR_EN(1), .LINE_BEATS(4)) dut (
        .clock(clock), .reset(reset),
        .m0_rd_req(m0_rd_req), .m0_rd_type(m0_rd_type), .m0_rd_addr(m0_rd_addr),
        .m0_rd_rdy(m0_rd_rdy), .m0_ret_valid(m0_ret_valid), .m0_ret_last(m0_ret_last),
        .m1_rd_req(m1_rd_req), .m1_rd_type(m1_rd_type), .m1_rd_addr(m1_rd_addr),
        .m1_rd_rdy(m1_rd_rdy), .m1_ret_valid(m1_ret_valid), .m1_ret_last(m1_ret_last),
        .ret_data_o(ret_data_o),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .busy(busy), .proto_err(proto_err)
    );

    axi_rd_arbiter #(.RR_EN(0), .LINE_BEATS(4)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_rd_req(m0_rd_req), .m0_rd_type(m0_rd_type), .m0_rd_addr(m0_rd_addr),
        .m0_rd_rdy(fp_m0_rd_rdy), .m0_ret_valid(fp_m0_ret_valid), .m0_ret_last(fp_m0_ret_last),
        .m1_rd_req(m1_rd_req), .m1_rd_type(m1_rd_type), .m1_rd_addr(m1_rd_addr),
        .m1_rd_rdy(fp_m1_rd_rdy), .m1_ret_valid(fp_m1_ret_valid), .m1_ret_last(fp_m1_ret_last),
        .ret_data_o(fp_ret_data_o),
        .rd_req(fp_rd_req), .rd_type(fp_rd_type), .rd_addr(fp_rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .busy(fp_busy), .proto_err(fp_proto_err)
    );

    always #5 clock = ~clock;

    // Every routed return beat must match the head of the expected queue.
    always @(negedge clock) begin
        beat_t e;
        logic [1:0] v;
        logic [1:0] l;
        v = {m1_ret_valid, m0_ret_valid};
        l = {m1_ret_last, m0_ret_last};
        for (int p = 0; p < 2; p++) begin
            if (v[p]) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ret_route: unexpected beat on port%0d data=%h, want none", p, ret_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.port !== p || e.data !== ret_data_o || e.last !== l[p]) begin
                        failures++;
                        $display("FAIL ret_route: got port%0d data=%h last=%b, want port%0d data=%h last=%b",
                                 p, ret_data_o, l[p], e.port, e.data, e.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_rd_req = 0; m0_rd_type = '0; m0_rd_addr = '0;
        m1_rd_req = 0; m1_rd_type = '0; m1_rd_addr = '0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
    endtask

    task automatic apply_reset();
        reset = 1;
        clear_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic raise_req(input int port, input logic [2:0] typ, input logic [31:0] addr);
        if (port == 0) begin
            m0_rd_req = 1; m0_rd_type = typ; m0_rd_addr = addr;
        end else begin
            m1_rd_req = 1; m1_rd_type = typ; m1_rd_addr = addr;
        end
    endtask

    task automatic check_bubble(input string name);
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_bubble: busy=%b rd_req=%b, want 0 0", name, busy, rd_req);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_beats: %0d expected beats never routed, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Starts with the DUT in REQ; returns at the start of the bubble cycle.
    task automatic serve(input int port, input logic [31:0] addr, input logic [2:0] typ,
                         input int rdy_delay, input int nbeats, input int last_at, input int exp_n);
        beat_t b;
        logic  err_b;
        for (int c = 0; c <= rdy_delay; c++) begin
            rd_rdy = (c == rdy_delay);
            @(negedge clock);
            tests_run++;
            if (rd_req !== 1'b1 || rd_addr !== addr || rd_type !== typ) begin
                failures++;
                $display("FAIL req_issue port%0d: rd_req=%b addr=%h type=%b, want 1 %h %b",
                         port, rd_req, rd_addr, rd_type, addr, typ);
            end
            tests_run++;
            if ({m1_rd_rdy, m0_rd_rdy} !== (rd_rdy ? ((port == 1) ? 2'b10 : 2'b01) : 2'b00)) begin
                failures++;
                $display("FAIL rdy_route port%0d: m1/m0_rd_rdy=%b%b with rd_rdy=%b", port,
                         m1_rd_rdy, m0_rd_rdy, rd_rdy);
            end
            tick();
        end
        rd_rdy = 0;
        if (port == 0) m0_rd_req = 0; else m1_rd_req = 0;
        for (int i = 0; i < nbeats; i++) begin
            err_b     = (i == last_at) != (i == exp_n - 1);
            ret_valid = 1;
            ret_last  = (i == last_at);
            ret_data  = 32'hd000_0000 | 32'(port << 8) | 32'(i);
            b.port = port;
            b.data = ret_data;
            b.last = (i == last_at) || (i == exp_n - 1);
            exp_q.push_back(b);
            @(negedge clock);
            tests_run++;
            if (proto_err !== err_b) begin
                failures++;
                $display("FAIL beat_err port%0d beat%0d: proto_err=%b, want %b", port, i, proto_err, err_b);
            end
            tick();
        end
        ret_valid = 0;
        ret_last  = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        tick();
        tick();
        @(negedge clock);
        tests_run++;
        if ({rd_req, rd_type, rd_addr, busy, proto_err} !== '0) begin
            failures++;
            $display("FAIL reset_bridge: rd_req=%b type=%b addr=%h busy=%b err=%b, want all 0",
                     rd_req, rd_type, rd_addr, busy, proto_err);
        end
        tests_run++;
        if ({m0_rd_rdy, m0_ret_valid, m0_ret_last, m1_rd_rdy, m1_ret_valid, m1_ret_last} !== '0) begin
            failures++;
            $display("FAIL reset_ports: %b%b%b %b%b%b, want 000 000", m0_rd_rdy, m0_ret_valid,
                     m0_ret_last, m1_rd_rdy, m1_ret_valid, m1_ret_last);
        end
        tests_run++;
        if ({fp_rd_req, fp_rd_type, fp_rd_addr, fp_busy, fp_proto_err, fp_m0_rd_rdy, fp_m0_ret_valid,
             fp_m0_ret_last, fp_m1_rd_rdy, fp_m1_ret_valid, fp_m1_ret_last} !== '0
            || fp_ret_data_o !== ret_data) begin
            failures++;
            $display("FAIL reset_fp: fixed-priority instance outputs not idle (rd_req=%b busy=%b)",
                     fp_rd_req, fp_busy);
        end
        tick();
        reset = 0;
    endtask

    task automatic test_line_read();
        raise_req(0, 3'b100, 32'h1c00_0000);
        @(negedge clock);
        tests_run++;
        if (rd_req !== 1'b0) begin
            failures++;
            $display("FAIL line_latency: rd_req=%b in request cycle, want 0", rd_req);
        end
        tick();
        serve(0, 32'h1c00_0000, 3'b100, 2, 4, 3, 4);
        check_bubble("line");
        tick();
    endtask

    task automatic test_tie_order();
        apply_reset();
        raise_req(0, 3'b100, 32'h0000_0a00);
        raise_req(1, 3'b100, 32'h0000_0b00);
        tick();
        @(negedge clock);
        tests_run++;
        if (rd_req !== 1'b1 || rd_addr !== 32'h0000_0a00) begin
            failures++;
            $display("FAIL tie_rr: rd_req=%b addr=%h, want 1 00000a00", rd_req, rd_addr);
        end
        tests_run++;
        if (fp_rd_req !== 1'b1 || fp_rd_addr !== 32'h0000_0b00) begin
            failures++;
            $display("FAIL tie_fixed: rd_req=%b addr=%h, want 1 00000b00", fp_rd_req, fp_rd_addr);
        end
        tick();
        serve(0, 32'h0000_0a00, 3'b100, 0, 4, 3, 4);
        // Port 0 comes straight back; round-robin must still favour waiting port 1.
        raise_req(0, 3'b010, 32'h0000_0a40);
        check_bubble("tie_first");
        tick();
        serve(1, 32'h0000_0b00, 3'b100, 0, 4, 3, 4);
        check_bubble("tie_second");
        tick();
        serve(0, 32'h0000_0a40, 3'b010, 0, 1, 0, 1);
        check_bubble("tie_third");
        tick();
    endtask

    task automatic test_word_read();
        raise_req(1, 3'b010, 32'h0000_1004);
        tick();
        serve(1, 32'h0000_1004, 3'b010, 1, 1, 0, 1);
        check_bubble("word_last");
        tick();
        raise_req(1, 3'b010, 32'h0000_1008);
        tick();
        serve(1, 32'h0000_1008, 3'b010, 0, 1, -1, 1);
        check_bubble("word_nolast");
        tick();
    endtask

    task automatic test_early_last();
        raise_req(0, 3'b100, 32'h0000_2000);
        tick();
        serve(0, 32'h0000_2000, 3'b100, 0, 2, 1, 4);
        check_bubble("early_last");
        tick();
    endtask

    task automatic test_stray_beats();
        ret_valid = 1;
        rd_rdy    = 1;
        ret_data  = 32'hbad0_0001;
        @(negedge clock);
        tests_run++;
        if (proto_err !== 1'b1 || m0_ret_valid !== 1'b0 || m1_ret_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_beat: proto_err=%b m0/m1_ret_valid=%b%b, want 1 00",
                     proto_err, m0_ret_valid, m1_ret_valid);
        end
        tick();
        ret_valid = 0;
        rd_rdy    = 0;
        @(negedge clock);
        tests_run++;
        if (proto_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_recover: proto_err=%b busy=%b, want 0 0", proto_err, busy);
        end
        tick();
        raise_req(1, 3'b010, 32'h0000_3000);
        tick();
        ret_valid = 1;
        @(negedge clock);
        tests_run++;
        if (proto_err !== 1'b1 || m1_ret_valid !== 1'b0 || rd_req !== 1'b1) begin
            failures++;
            $display("FAIL req_beat: proto_err=%b m1_ret_valid=%b rd_req=%b, want 1 0 1",
                     proto_err, m1_ret_valid, rd_req);
        end
        tick();
        ret_valid = 0;
        serve(1, 32'h0000_3000, 3'b010, 0, 1, 0, 1);
        check_bubble("stray");
        tick();
    endtask

    task automatic test_reset_mid_burst();
        beat_t b;
        raise_req(0, 3'b100, 32'h0000_4000);
        tick();
        rd_rdy = 1;
        tick();
        rd_rdy    = 0;
        m0_rd_req = 0;
        ret_valid = 1;
        ret_data  = 32'hd000_0000;
        b.port = 0; b.data = ret_data; b.last = 1'b0;
        exp_q.push_back(b);
        @(negedge clock);
        tests_run++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_beat0: proto_err=%b, want 0", proto_err);
        end
        tick();
        ret_valid = 0;
        reset     = 1;
        tick();
        reset = 0;
        for (int k = 1; k < 4; k++) begin
            ret_valid = 1;
            ret_last  = (k == 3);
            ret_data  = 32'hd000_0000 | 32'(k);
            @(negedge clock);
            tests_run++;
            if (busy !== 1'b0 || rd_req !== 1'b0 || proto_err !== 1'b1) begin
                failures++;
                $display("FAIL midrst_trail%0d: busy=%b rd_req=%b proto_err=%b, want 0 0 1",
                         k, busy, rd_req, proto_err);
            end
            tick();
        end
        ret_valid = 0;
        ret_last  = 0;
        check_bubble("midrst");
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_line_read();
        test_tie_order();
        test_word_read();
        test_early_last();
        test_stray_beats();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
